// File: rtl/fp_widen_pkg.sv
// fp_widen_pkg: shared FSM states, bias helpers and class decode for float_widen
package fp_widen_pkg;
  typedef enum logic [1:0] {GET_A, CONVERT, NORMALISE, PUT_RESULT} state_e;
  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction
  // Output exponent of an input subnormal before any normalising shift.
  function automatic int subnormal_start_exp(input int in_exp, input int out_exp);
    return bias(out_exp) - bias(in_exp) + 1;
  endfunction
  function automatic logic is_nan(input logic exp_ones, input logic man_nz);
    return exp_ones & man_nz;
  endfunction
  function automatic logic is_inf(input logic exp_ones, input logic man_nz);
    return exp_ones & ~man_nz;
  endfunction
  function automatic logic is_zero(input logic exp_zero, input logic man_nz);
    return exp_zero & ~man_nz;
  endfunction
  function automatic logic is_sub(input logic exp_zero, input logic man_nz);
    return exp_zero & man_nz;
  endfunction
endpackage

// File: rtl/float_widen.sv
// float_widen: exact IEEE-754 widening converter with stb/ack handshakes
//   clock/rst                        rising-edge clock, synchronous active-high reset
//   input_a/_stb/_ack                source operand handshake
//   output_result/_stb/_ack          converted value handshake
module float_widen
  import fp_widen_pkg::*;
#(
  parameter int IN_EXP    = 8,
  parameter int IN_MAN    = 23,
  parameter int OUT_EXP   = 11,
  parameter int OUT_MAN   = 52,
  parameter int QUIET_NAN = 0,
  parameter int FTZ       = 0
) (
  input  logic                         clock,
  input  logic                         rst,
  input  logic [IN_EXP+IN_MAN:0]       input_a,
  input  logic                         input_a_stb,
  output logic                         input_a_ack,
  output logic [OUT_EXP+OUT_MAN:0]     output_result,
  output logic                         output_result_stb,
  input  logic                         output_result_ack
);
  localparam int IW = 1 + IN_EXP + IN_MAN;
  localparam int OW = 1 + OUT_EXP + OUT_MAN;
  localparam logic [OUT_EXP-1:0] EXP_ADJ = OUT_EXP'(bias(OUT_EXP) - bias(IN_EXP));
  localparam logic [OUT_EXP-1:0] SUB_EXP = OUT_EXP'(subnormal_start_exp(IN_EXP, OUT_EXP));
  localparam logic [OUT_MAN-1:0] QBIT = OUT_MAN'(1) << (OUT_MAN - 1);
  if (!(OUT_EXP > IN_EXP && OUT_MAN >= IN_MAN)) begin : g_param_check
    $error("float_widen: output format must be strictly wider in exponent and no narrower in mantissa");
  end
  state_e state_q, state_d;
  logic [IW-1:0] a_q, a_d;
  logic [OUT_EXP-1:0] wexp_q, wexp_d;
  logic [OUT_MAN:0] wman_q, wman_d;
  logic [OW-1:0] res_q, res_d;
  logic ack_q, ack_d, stb_q, stb_d;
  logic sign, exp_ones, exp_zero, man_nz, nan, inf, zero, sub, flush;
  logic [IN_EXP-1:0] a_exp;
  logic [IN_MAN-1:0] a_man;
  logic [OUT_MAN-1:0] man_ext, cls_man;
  logic [OUT_EXP-1:0] cls_exp;
  logic [OUT_MAN:0] conv_man;
  assign sign     = a_q[IW-1];
  assign a_exp    = a_q[IN_MAN +: IN_EXP];
  assign a_man    = a_q[IN_MAN-1:0];
  assign exp_ones = &a_exp;
  assign exp_zero = ~|a_exp;
  assign man_nz   = |a_man;
  assign nan      = is_nan(exp_ones, man_nz);
  assign inf      = is_inf(exp_ones, man_nz);
  assign zero     = is_zero(exp_zero, man_nz);
  assign sub      = is_sub(exp_zero, man_nz);
  assign flush    = zero | (sub & (FTZ != 0));
  assign man_ext  = OUT_MAN'(a_man) << (OUT_MAN - IN_MAN);
  assign cls_exp  = (nan | inf) ? '1 : flush ? '0 : sub ? SUB_EXP : OUT_EXP'(a_exp) + EXP_ADJ;
  assign cls_man  = flush ? '0 : (nan && QUIET_NAN != 0) ? (man_ext | QBIT) : man_ext;
  // Bit OUT_MAN of the work mantissa is the "normalised" flag: every class except a
  // live subnormal enters NORMALISE with it already set and finishes in one step.
  assign conv_man = (sub && !flush) ? {1'b0, man_ext} : {1'b1, cls_man};
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    wexp_d  = wexp_q;
    wman_d  = wman_q;
    res_d   = res_q;
    ack_d   = ack_q;
    stb_d   = stb_q;
    case (state_q)
      GET_A: begin
        ack_d = 1'b1;
        if (ack_q && input_a_stb) begin
          a_d     = input_a;
          ack_d   = 1'b0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        wexp_d  = cls_exp;
        wman_d  = conv_man;
        state_d = NORMALISE;
      end
      NORMALISE: begin
        if (wman_q[OUT_MAN]) begin
          res_d   = {sign, wexp_q, wman_q[OUT_MAN-1:0]};
          stb_d   = 1'b1;
          state_d = PUT_RESULT;
        end else begin
          wman_d = wman_q << 1;
          wexp_d = wexp_q - OUT_EXP'(1);
        end
      end
      default: begin
        if (output_result_ack) begin
          stb_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = GET_A;
        end
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= GET_A;
      a_q     <= '0;
      wexp_q  <= '0;
      wman_q  <= '0;
      res_q   <= '0;
      ack_q   <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      wexp_q  <= wexp_d;
      wman_q  <= wman_d;
      res_q   <= res_d;
      ack_q   <= ack_d;
      stb_q   <= stb_d;
    end
  end
  assign input_a_ack       = ack_q;
  assign output_result     = res_q;
  assign output_result_stb = stb_q;
endmodule

// File: tb/tb_float_widen.sv
// tb_float_widen: directed checks of float_widen in default, FTZ/quiet-NaN and half-to-single builds
module tb_float_widen;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, a_stb, r_ack, ack0, ack1, stb0, stb1;
  logic [31:0] a;
  logic [63:0] r0, r1;
  logic [15:0] h;
  logic h_stb, h_ack, hr_stb, hr_ack;
  logic [31:0] hr;
  int checks = 0;
  int failures = 0;
  float_widen u0 (
    .clock(clk), .rst(rst), .input_a(a), .input_a_stb(a_stb), .input_a_ack(ack0),
    .output_result(r0), .output_result_stb(stb0), .output_result_ack(r_ack)
  );
  float_widen #(.QUIET_NAN(1), .FTZ(1)) u1 (
    .clock(clk), .rst(rst), .input_a(a), .input_a_stb(a_stb), .input_a_ack(ack1),
    .output_result(r1), .output_result_stb(stb1), .output_result_ack(r_ack)
  );
  float_widen #(.IN_EXP(5), .IN_MAN(10), .OUT_EXP(8), .OUT_MAN(23)) u2 (
    .clock(clk), .rst(rst), .input_a(h), .input_a_stb(h_stb), .input_a_ack(h_ack),
    .output_result(hr), .output_result_stb(hr_stb), .output_result_ack(hr_ack)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic conv(input logic [31:0] v, input logic [63:0] e0, input logic [63:0] e1,
                      input int l0, input int l1);
    int n0 = 0;
    int n1 = 0;
    for (int t = 0; t < 50 && !(ack0 && ack1); t++) @(negedge clk);
    chk($sformatf("%h in_ack", v), 64'(ack0 & ack1), 64'(1));
    a = v;
    a_stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_stb = 1'b0;
    for (int n = 1; n <= 40 && (n0 == 0 || n1 == 0); n++) begin
      @(posedge clk);
      @(negedge clk);
      if (stb0 && n0 == 0) n0 = n;
      if (stb1 && n1 == 0) n1 = n;
    end
    chk($sformatf("%h lat_dflt", v), 64'(n0), 64'(l0));
    chk($sformatf("%h lat_ftzq", v), 64'(n1), 64'(l1));
    chk($sformatf("%h res_dflt", v), r0, e0);
    chk($sformatf("%h res_ftzq", v), r1, e1);
    r_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    r_ack = 1'b0;
    chk($sformatf("%h stb_drop", v), 64'(stb0 | stb1), 64'(0));
  endtask
  task automatic conv_h(input logic [15:0] v, input logic [31:0] e, input int l);
    int n0 = 0;
    for (int t = 0; t < 50 && !h_ack; t++) @(negedge clk);
    h = v;
    h_stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    h_stb = 1'b0;
    for (int n = 1; n <= 40 && n0 == 0; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (hr_stb) n0 = n;
    end
    chk($sformatf("h%h lat", v), 64'(n0), 64'(l));
    chk($sformatf("h%h res", v), 64'(hr), 64'(e));
    hr_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    hr_ack = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    rst = 1'b1; a = '0; a_stb = 1'b0; r_ack = 1'b0;
    h = '0; h_stb = 1'b0; hr_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ack", 64'({ack0, ack1, h_ack}), 64'(0));
    chk("reset stb", 64'({stb0, stb1, hr_stb}), 64'(0));
    chk("reset res", r0 | r1 | 64'(hr), 64'(0));
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ack after reset", 64'({ack0, ack1, h_ack}), 64'(7));
    conv(32'h3F800000, 64'h3FF0000000000000, 64'h3FF0000000000000, 2, 2);
    conv(32'h80000000, 64'h8000000000000000, 64'h8000000000000000, 2, 2);
    conv(32'h00000001, 64'h36A0000000000000, 64'h0000000000000000, 25, 2);
    conv(32'h007FFFFF, 64'h380FFFFFC0000000, 64'h0000000000000000, 3, 2);
    conv(32'h807FFFFF, 64'hB80FFFFFC0000000, 64'h8000000000000000, 3, 2);
    conv(32'h7F800000, 64'h7FF0000000000000, 64'h7FF0000000000000, 2, 2);
    conv(32'h7F800001, 64'h7FF0000020000000, 64'h7FF8000020000000, 2, 2);
    conv(32'hC0490FDB, 64'hC00921FB60000000, 64'hC00921FB60000000, 2, 2);
    conv(32'h7F7FFFFF, 64'h47EFFFFFE0000000, 64'h47EFFFFFE0000000, 2, 2);
    a = 32'h40000000;
    a_stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 32'h3F800000;
    for (int t = 0; t < 10 && !stb0; t++) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("bp first res", r0, 64'h4000000000000000);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp hold res %0d", i), r0, 64'h4000000000000000);
      chk($sformatf("bp hold stb %0d", i), 64'(stb0), 64'(1));
      chk($sformatf("bp hold ack %0d", i), 64'(ack0), 64'(0));
    end
    r_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    r_ack = 1'b0;
    chk("bp stb drop", 64'(stb0), 64'(0));
    chk("bp ack rise", 64'(ack0), 64'(1));
    @(posedge clk);
    @(negedge clk);
    a_stb = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("bp second stb", 64'(stb0), 64'(1));
    chk("bp second res", r0, 64'h3FF0000000000000);
    r_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    r_ack = 1'b0;
    a = 32'h00000001;
    a_stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_stb = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst mid stb", 64'({stb0, stb1}), 64'(0));
    chk("rst mid res", r0 | r1, 64'(0));
    chk("rst mid ack", 64'({ack0, ack1}), 64'(0));
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst mid ack rise", 64'({ack0, ack1}), 64'(3));
    conv(32'h40000000, 64'h4000000000000000, 64'h4000000000000000, 2, 2);
    conv_h(16'h3C00, 32'h3F800000, 2);
    conv_h(16'h0001, 32'h33800000, 12);
    conv_h(16'hFC00, 32'hFF800000, 2);
    conv_h(16'h7E00, 32'h7FC00000, 2);
    conv_h(16'h8000, 32'h80000000, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
